// File: rtl/safecrack_pkg.sv
// Shared types and constant helpers for the safecrack code lock.
package safecrack_pkg;

   typedef enum logic [1:0] {StEntry, StOpen, StProg, StLockout} state_t;

   localparam int unsigned MaxBtnW = 8;

   // All-ones pattern of btn_w bits: the idle (nothing pressed) button vector.
   function automatic logic [MaxBtnW-1:0] btn_idle(int unsigned btn_w);
      return MaxBtnW'((32'd1 << btn_w) - 32'd1);
   endfunction

   // Reset code digit i: idle with bit (i mod btn_w) low.
   function automatic logic [MaxBtnW-1:0] default_code(int unsigned i, int unsigned btn_w);
      return btn_idle(btn_w) & ~(MaxBtnW'(1) << (i % btn_w));
   endfunction

endpackage

// File: rtl/safecrack_btn_edge.sv
// Button press detector: flags the single cycle where btn leaves the idle pattern.
module safecrack_btn_edge
   import safecrack_pkg::*;
#(
   parameter int unsigned BTN_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [BTN_W-1:0] btn,
   output logic             press_vld,
   output logic [BTN_W-1:0] press
);

   localparam logic [MaxBtnW-1:0] IdleFull = btn_idle(BTN_W);
   localparam logic [BTN_W-1:0]   Idle     = IdleFull[BTN_W-1:0];

   logic [BTN_W-1:0] prev_q;

   always_ff @(posedge clk) begin
      if (rst) prev_q <= Idle;
      else     prev_q <= btn;
   end

   assign press_vld = (prev_q == Idle) && (btn != Idle);
   assign press     = btn;

endmodule

// File: rtl/safecrack_gen.sv
// Code lock: digit entry with error counting, timed lockout, and in-place reprogramming.
module safecrack_gen
   import safecrack_pkg::*;
#(
   parameter int unsigned DIGITS        = 4,
   parameter int unsigned BTN_W         = 4,
   parameter int unsigned MAX_ERR       = 3,
   parameter int unsigned LOCK_SEC      = 10,
   parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [BTN_W-1:0]    btn,
   input  logic                ms,
   input  logic                relock,
   output logic                unlocked,
   output logic                locked_out,
   output logic [DIGITS-1:0]   leds_ok,
   output logic [MAX_ERR-1:0]  leds_err,
   output logic [LOCK_SEC-1:0] leds_sec
);

   localparam int unsigned IdxW = $clog2(DIGITS);
   localparam int unsigned ErrW = $clog2(MAX_ERR + 1);
   localparam int unsigned SecW = (LOCK_SEC > 1) ? $clog2(LOCK_SEC) : 1;
   localparam int unsigned PreW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

   state_t                       state_q, state_d;
   logic [IdxW-1:0]              idx_q, idx_d;
   logic [ErrW-1:0]              err_q, err_d, err_inc;
   logic [PreW-1:0]              presc_q, presc_d;
   logic [SecW-1:0]              sec_q, sec_d;
   logic [DIGITS-1:0]            leds_ok_q, leds_ok_d;
   logic [MAX_ERR-1:0]           leds_err_q, leds_err_d;
   logic [LOCK_SEC-1:0]          leds_sec_q, leds_sec_d;
   logic [DIGITS-1:0][BTN_W-1:0] code_q, code_d, shadow_q, shadow_d, code_rst;

   logic             press_vld;
   logic [BTN_W-1:0] press;
   logic             single, match, last_idx, err_full, prog_press, tick, lock_done;

   safecrack_btn_edge #(
      .BTN_W (BTN_W)
   ) u_btn_edge (
      .clk       (clk),
      .rst       (rst),
      .btn       (btn),
      .press_vld (press_vld),
      .press     (press)
   );

   for (genvar g = 0; g < DIGITS; g++) begin : g_code_rst
      localparam logic [MaxBtnW-1:0] Full = default_code(g, BTN_W);
      assign code_rst[g] = Full[BTN_W-1:0];
   end

   assign single     = $onehot(~press);
   assign match      = press_vld && single && (press == code_q[idx_q]);
   assign last_idx   = (idx_q == IdxW'(DIGITS - 1));
   assign err_inc    = err_q + ErrW'(1);
   assign err_full   = (err_inc == ErrW'(MAX_ERR));
   assign prog_press = press_vld && single;
   assign tick       = (presc_q == PreW'(TICKS_PER_SEC - 1));
   assign lock_done  = tick && (sec_q == SecW'(LOCK_SEC - 1));

   always_ff @(posedge clk) begin
      if (rst) state_q <= StEntry;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StEntry: begin
            if (press_vld && !match && err_full) state_d = StLockout;
            else if (match && last_idx)          state_d = StOpen;
         end
         StOpen: begin
            if (relock)  state_d = StEntry;
            else if (ms) state_d = StProg;
         end
         StProg: begin
            if (!ms)                         state_d = StOpen;
            else if (prog_press && last_idx) state_d = StEntry;
         end
         StLockout: if (lock_done) state_d = StEntry;
         default: state_d = StEntry;
      endcase
   end

   always_comb begin
      unlocked   = (state_q == StOpen);
      locked_out = (state_q == StLockout);
      leds_ok    = leds_ok_q;
      leds_err   = leds_err_q;
      leds_sec   = leds_sec_q;
   end

   always_comb begin
      idx_d      = idx_q;
      err_d      = err_q;
      presc_d    = presc_q;
      sec_d      = sec_q;
      leds_ok_d  = leds_ok_q;
      leds_err_d = leds_err_q;
      leds_sec_d = leds_sec_q;
      code_d     = code_q;
      shadow_d   = shadow_q;
      unique case (state_q)
         StEntry: begin
            if (match && last_idx) begin
               idx_d      = '0;
               leds_ok_d  = '0;
               err_d      = '0;
               leds_err_d = '0;
            end else if (match) begin
               idx_d     = idx_q + IdxW'(1);
               leds_ok_d = (leds_ok_q << 1) | DIGITS'(1);
            end else if (press_vld) begin
               idx_d      = '0;
               leds_ok_d  = '0;
               err_d      = (err_q < ErrW'(MAX_ERR)) ? err_inc : err_q;
               leds_err_d = (leds_err_q << 1) | MAX_ERR'(1);
            end
         end
         StOpen: idx_d = '0;
         StProg: begin
            if (!ms) begin
               idx_d = '0;
            end else if (prog_press) begin
               shadow_d[idx_q] = press;
               if (last_idx) begin
                  // Final digit goes straight into the code alongside the earlier shadow digits.
                  code_d        = shadow_q;
                  code_d[idx_q] = press;
                  idx_d         = '0;
               end else begin
                  idx_d = idx_q + IdxW'(1);
               end
            end
         end
         StLockout: begin
            if (lock_done) begin
               presc_d    = '0;
               sec_d      = '0;
               leds_sec_d = '0;
               err_d      = '0;
               leds_err_d = '0;
            end else if (tick) begin
               presc_d    = '0;
               sec_d      = sec_q + SecW'(1);
               leds_sec_d = (leds_sec_q << 1) | LOCK_SEC'(1);
            end else begin
               presc_d = presc_q + PreW'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q      <= '0;
         err_q      <= '0;
         presc_q    <= '0;
         sec_q      <= '0;
         leds_ok_q  <= '0;
         leds_err_q <= '0;
         leds_sec_q <= '0;
         code_q     <= code_rst;
         shadow_q   <= '0;
      end else begin
         idx_q      <= idx_d;
         err_q      <= err_d;
         presc_q    <= presc_d;
         sec_q      <= sec_d;
         leds_ok_q  <= leds_ok_d;
         leds_err_q <= leds_err_d;
         leds_sec_q <= leds_sec_d;
         code_q     <= code_d;
         shadow_q   <= shadow_d;
      end
   end

endmodule

// File: tb/tb_safecrack_gen.sv
// Directed bench for safecrack_gen with a 4-cycle second.
module tb_safecrack_gen;

   localparam logic [3:0] IDLE = 4'b1111;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] btn = IDLE;
   logic       ms = 1'b0;
   logic       relock = 1'b0;
   logic       unlocked, locked_out;
   logic [3:0] leds_ok;
   logic [2:0] leds_err;
   logic [9:0] leds_sec;

   int checks = 0;
   int errors = 0;

   safecrack_gen #(
      .DIGITS        (4),
      .BTN_W         (4),
      .MAX_ERR       (3),
      .LOCK_SEC      (10),
      .TICKS_PER_SEC (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn        (btn),
      .ms         (ms),
      .relock     (relock),
      .unlocked   (unlocked),
      .locked_out (locked_out),
      .leds_ok    (leds_ok),
      .leds_err   (leds_err),
      .leds_sec   (leds_sec)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Returns at the negedge one posedge after the press, with btn released.
   task automatic press(input logic [3:0] v);
      @(negedge clk) btn = v;
      @(negedge clk) btn = IDLE;
   endtask

   task automatic pulse_relock();
      @(negedge clk) relock = 1'b1;
      @(negedge clk) relock = 1'b0;
   endtask

   task automatic pulse_rst();
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic enter_default();
      press(4'b1110);
      press(4'b1101);
      press(4'b1011);
      press(4'b0111);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({unlocked, locked_out} !== 2'b00) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 00", {unlocked, locked_out});
      end
      checks++;
      if ({leds_ok, leds_err, leds_sec} !== 17'd0) begin
         errors++;
         $display("FAIL reset_leds: got %b expected 0", {leds_ok, leds_err, leds_sec});
      end
   endtask

   task automatic test_open_default();
      logic [3:0] codes [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      logic [3:0] exp_ok [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b0000};
      for (int i = 0; i < 4; i++) begin
         press(codes[i]);
         checks++;
         if (leds_ok !== exp_ok[i]) begin
            errors++;
            $display("FAIL open_leds_ok[%0d]: got %b expected %b", i, leds_ok, exp_ok[i]);
         end
         checks++;
         if (unlocked !== (i == 3)) begin
            errors++;
            $display("FAIL open_unlocked[%0d]: got %b expected %b", i, unlocked, i == 3);
         end
      end
      pulse_relock();
      checks++;
      if (unlocked !== 1'b0) begin
         errors++;
         $display("FAIL relock: got unlocked=%b expected 0", unlocked);
      end
   endtask

   task automatic test_wrong_digit();
      press(4'b1110);
      press(4'b1011);
      checks++;
      if ({leds_ok, leds_err} !== {4'b0000, 3'b001}) begin
         errors++;
         $display("FAIL wrong_leds: got ok=%b err=%b expected ok=0000 err=001", leds_ok, leds_err);
      end
      checks++;
      if (dut.idx_q !== 2'd0) begin
         errors++;
         $display("FAIL wrong_idx: got %0d expected 0", dut.idx_q);
      end
      enter_default();
      checks++;
      if ({unlocked, leds_err} !== {1'b1, 3'b000}) begin
         errors++;
         $display("FAIL retry_open: got unlocked=%b err=%b expected 1 000", unlocked, leds_err);
      end
      pulse_relock();
   endtask

   task automatic test_multibit_and_hold();
      press(4'b1100);
      checks++;
      if (leds_err !== 3'b001) begin
         errors++;
         $display("FAIL multibit_err: got %b expected 001", leds_err);
      end
      @(negedge clk) btn = 4'b1110;
      repeat (4) @(negedge clk);
      btn = IDLE;
      checks++;
      if (leds_ok !== 4'b0001) begin
         errors++;
         $display("FAIL held_no_repeat: got %b expected 0001", leds_ok);
      end
      press(4'b1101);
      press(4'b1011);
      press(4'b0111);
      checks++;
      if ({unlocked, leds_err} !== {1'b1, 3'b000}) begin
         errors++;
         $display("FAIL held_open: got unlocked=%b err=%b expected 1 000", unlocked, leds_err);
      end
      pulse_relock();
   endtask

   task automatic test_lockout();
      int         cnt;
      logic [9:0] exp_sec;
      repeat (3) press(4'b1011);
      checks++;
      if ({locked_out, leds_err} !== {1'b1, 3'b111}) begin
         errors++;
         $display("FAIL lock_enter: got lo=%b err=%b expected 1 111", locked_out, leds_err);
      end
      cnt = 0;
      while (locked_out === 1'b1 && cnt < 100) begin
         exp_sec = 10'((32'd1 << (cnt / 4)) - 32'd1);
         checks++;
         if (leds_sec !== exp_sec) begin
            errors++;
            $display("FAIL lock_sec[%0d]: got %b expected %b", cnt, leds_sec, exp_sec);
         end
         cnt++;
         @(negedge clk);
         if (cnt == 10) btn = 4'b1110;
         if (cnt == 12) btn = IDLE;
      end
      checks++;
      if (cnt !== 40) begin
         errors++;
         $display("FAIL lock_duration: got %0d cycles expected 40", cnt);
      end
      checks++;
      if ({leds_ok, leds_err, leds_sec} !== 17'd0) begin
         errors++;
         $display("FAIL lock_exit: got ok=%b err=%b sec=%b expected all 0",
                  leds_ok, leds_err, leds_sec);
      end
   endtask

   task automatic test_program();
      enter_default();
      @(negedge clk) ms = 1'b1;
      @(negedge clk);
      checks++;
      if (unlocked !== 1'b0) begin
         errors++;
         $display("FAIL prog_enter: got unlocked=%b expected 0", unlocked);
      end
      press(4'b0111);
      press(4'b1011);
      press(4'b1101);
      press(4'b1110);
      ms = 1'b0;
      press(4'b1110);
      checks++;
      if ({unlocked, leds_err} !== {1'b0, 3'b001}) begin
         errors++;
         $display("FAIL old_code_err: got unlocked=%b err=%b expected 0 001", unlocked, leds_err);
      end
      press(4'b0111);
      press(4'b1011);
      press(4'b1101);
      press(4'b1110);
      checks++;
      if ({unlocked, leds_err} !== {1'b1, 3'b000}) begin
         errors++;
         $display("FAIL new_code_open: got unlocked=%b err=%b expected 1 000", unlocked, leds_err);
      end
   endtask

   task automatic test_prog_abort();
      @(negedge clk) ms = 1'b1;
      press(4'b1110);
      press(4'b1101);
      @(negedge clk) ms = 1'b0;
      @(negedge clk);
      checks++;
      if (unlocked !== 1'b1) begin
         errors++;
         $display("FAIL abort_open: got unlocked=%b expected 1", unlocked);
      end
      pulse_relock();
      press(4'b0111);
      press(4'b1011);
      press(4'b1101);
      press(4'b1110);
      checks++;
      if (unlocked !== 1'b1) begin
         errors++;
         $display("FAIL abort_code_kept: got unlocked=%b expected 1", unlocked);
      end
      pulse_relock();
   endtask

   task automatic test_reset_mid();
      repeat (3) press(4'b1110);
      repeat (9) @(negedge clk);
      pulse_rst();
      checks++;
      if ({unlocked, locked_out, leds_ok, leds_err, leds_sec} !== 19'd0) begin
         errors++;
         $display("FAIL rst_lockout: got %b expected 0",
                  {unlocked, locked_out, leds_ok, leds_err, leds_sec});
      end
      enter_default();
      checks++;
      if (unlocked !== 1'b1) begin
         errors++;
         $display("FAIL rst_lockout_default: got unlocked=%b expected 1", unlocked);
      end
      @(negedge clk) ms = 1'b1;
      press(4'b0111);
      press(4'b0111);
      pulse_rst();
      ms = 1'b0;
      checks++;
      if ({unlocked, locked_out, leds_ok, leds_err, leds_sec} !== 19'd0) begin
         errors++;
         $display("FAIL rst_prog: got %b expected 0",
                  {unlocked, locked_out, leds_ok, leds_err, leds_sec});
      end
      enter_default();
      checks++;
      if (unlocked !== 1'b1) begin
         errors++;
         $display("FAIL rst_prog_default: got unlocked=%b expected 1", unlocked);
      end
   endtask

   initial begin
      test_reset();
      test_open_default();
      test_wrong_digit();
      test_multibit_and_hold();
      test_lockout();
      test_program();
      test_prog_abort();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/safecrack_gen.md
SAFECRACK_GEN -- requirements
Module: safecrack_gen

Interface
REQ-001 SHALL have parameter DIGITS, default 4: code length in presses, 2..8.
REQ-002 SHALL have parameter BTN_W, default 4: button count, 2..8.
REQ-003 SHALL have parameter MAX_ERR, default 3: wrong-code attempts before lockout, 1..7.
REQ-004 SHALL have parameter LOCK_SEC, default 10: lockout duration in seconds, 1..16.
REQ-005 SHALL have parameter TICKS_PER_SEC, default 50_000_000: clk cycles per second.
REQ-006 SHALL have port clk input 1: clock; all logic on posedge.
REQ-007 SHALL have port rst input 1: reset, synchronous, active-high.
REQ-008 SHALL have port btn input BTN_W: buttons, active-low; all-ones = idle.
REQ-009 SHALL have port ms input 1: level, program-mode request.
REQ-010 SHALL have port relock input 1: level, closes an open safe.
REQ-011 SHALL have port unlocked output 1: high only in OPEN.
REQ-012 SHALL have port locked_out output 1: high only in LOCKOUT.
REQ-013 SHALL have port leds_ok output DIGITS: thermometer of correct digits in the current attempt.
REQ-014 SHALL have port leds_err output MAX_ERR: thermometer of failed attempts.
REQ-015 SHALL have port leds_sec output LOCK_SEC: thermometer of elapsed lockout seconds.

Function
REQ-016 SHALL accept a press only on the cycle btn changes from idle to non-idle; held buttons SHALL NOT repeat.
REQ-017 SHALL treat a press with more than one bit low as a wrong digit.
REQ-018 SHALL use FSM states ENTRY, OPEN, PROG, LOCKOUT.
REQ-019 ENTRY: each press SHALL be compared with code[idx]; match increments idx and leds_ok.
REQ-020 ENTRY: a match with idx = DIGITS-1 SHALL go to OPEN next cycle, clear idx, leds_ok and error count.
REQ-021 ENTRY: a mismatch SHALL clear idx and leds_ok and increment the error count, so the whole code is re-entered.
REQ-022 A mismatch that brings the error count to MAX_ERR SHALL go to LOCKOUT next cycle.
REQ-023 LOCKOUT: presses SHALL be ignored; a prescaler SHALL count TICKS_PER_SEC cycles per second and set the next leds_sec bit each second.
REQ-024 LOCKOUT SHALL end on the second-LOCK_SEC tick. The next cycle SHALL be ENTRY with the error count, leds_sec and the prescaler cleared. Total duration is exactly LOCK_SEC*TICKS_PER_SEC cycles.
REQ-025 OPEN: relock = 1 SHALL go to ENTRY. Otherwise ms = 1 SHALL go to PROG. relock SHALL win if both are high.
REQ-026 PROG: each valid single-bit press SHALL be stored into shadow[idx]. Multi-bit presses SHALL be ignored.
REQ-027 PROG: after the DIGITS-th press, shadow SHALL be committed to code in one cycle, then the FSM goes to ENTRY.
REQ-028 PROG: ms falling before completion SHALL abort to OPEN, leave code unchanged and clear idx.
REQ-029 Counters SHALL saturate and never wrap. The idx width is clog2(DIGITS). The error width is clog2(MAX_ERR+1).
REQ-030 Outputs SHALL be registered or decoded from the state register only, with no combinational path from btn.

Reset
REQ-031 rst SHALL force ENTRY, and clear idx, error count, prescaler, second count and the edge-detect register (edge register = idle).
REQ-032 rst SHALL load code[i] = all-ones with bit (i mod BTN_W) cleared.
REQ-033 After rst, every output SHALL be 0.
REQ-034 rst SHALL take priority in every state, including mid-PROG, where the shadow is discarded.

Structure
REQ-035 Package safecrack_pkg SHALL hold the state_t enum, the BTN_IDLE constant function and the default-code function.
REQ-036 Sub-module safecrack_btn_edge SHALL hold the btn press detector, outputting a one-cycle press_vld and the captured press value.

Verification
REQ-037 With defaults and TICKS_PER_SEC=4, pressing 1110,1101,1011,0111 SHALL give unlocked=1 one cycle after the 4th press, with leds_ok stepping 0001..0111 before that.
REQ-038 Pressing 1110 then 1011 SHALL give leds_ok=0000, leds_err=001 and idx=0; the correct code afterwards SHALL still open and clear leds_err.
REQ-039 Three wrong attempts SHALL give locked_out=1 for exactly 40 cycles, with leds_sec filling 1 bit per 4 cycles; presses in that window SHALL be ignored; the FSM then returns to ENTRY with leds_err=000.
REQ-040 In OPEN, with ms=1, pressing 0111,1011,1101,1110, then ms=0: ENTRY SHALL be entered, the new code SHALL open, and the old code SHALL add an error.
REQ-041 In PROG, after 2 presses, dropping ms SHALL return to OPEN, and the old code SHALL still open after relock.
REQ-042 rst pulsed mid-LOCKOUT or mid-PROG SHALL give all outputs 0 next cycle, and the default code SHALL open.
